// File: rtl/reg_slice_skid.sv
// -----------------------------------------------------------------------------
// reg_slice_skid
//
// Two-entry valid/ready pipeline register (skid buffer). Breaks the
// combinational ready path between pipeline stages while sustaining one
// transfer per cycle. Data is presented downstream straight from the main
// register; a second (skid) register absorbs the word that upstream pushes
// in the cycle the downstream stalls.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    upstream data (N bits)
//   in_valid   upstream data valid
//   in_ready   slice can accept; derived only from flops
//   out_data   downstream data, driven from the main register
//   out_valid  out_data valid; derived only from flops
//   out_ready  downstream accepts
//   occupancy  number of held entries, 0..2
// -----------------------------------------------------------------------------
module reg_slice_skid #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   occupancy
);

    // State encoding is {main_valid, skid_valid}; 2'b01 cannot be reached
    // and is steered back to EMPTY.
    typedef enum logic [1:0] {
        S_EMPTY   = 2'b00,
        S_ILLEGAL = 2'b01,
        S_BUSY    = 2'b10,
        S_FULL    = 2'b11
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [N-1:0] main_data;
    logic [N-1:0] skid_data;
    logic         init_done;
    logic         main_valid;
    logic         skid_valid;

    logic         in_xfer;
    logic         out_xfer;
    logic         main_load_in;
    logic         main_load_skid;
    logic         skid_load_in;

    assign main_valid = state[1];
    assign skid_valid = state[0];

    // Transfer strobes only use flop-derived handshake outputs, so the
    // external ready/valid inputs never feed the opposite handshake output.
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_EMPTY;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and data-load decisions
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_nxt      = state;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load_in   = 1'b0;

        case (state)
            S_EMPTY: begin
                if (in_xfer) begin
                    main_load_in = 1'b1;
                    state_nxt    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (in_xfer && out_xfer) begin
                    // Pass-through: the departing word is replaced in place.
                    main_load_in = 1'b1;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new word in the skid slot.
                    skid_load_in = 1'b1;
                    state_nxt    = S_FULL;
                end else if (out_xfer) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so only an output transfer can occur.
                if (out_xfer) begin
                    main_load_skid = 1'b1;
                    state_nxt      = S_BUSY;
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Data registers
    // -------------------------------------------------------------------------
    // NOTE: the data registers are cleared on reset so out_data reads zero
    // while the slice is held in reset; they hold their value otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_data <= '0;
            skid_data <= '0;
        end else begin
            if (main_load_in) begin
                main_data <= in_data;
            end else if (main_load_skid) begin
                main_data <= skid_data;
            end
            if (skid_load_in) begin
                skid_data <= in_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (functions of registered state only)
    // -------------------------------------------------------------------------
    always_comb begin
        out_data  = main_data;
        out_valid = main_valid;
        in_ready  = ~skid_valid & init_done;
        occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
    end

endmodule

// File: doc/reg_slice_skid.md
Name: reg_slice_skid

Overview:
- Two-entry valid/ready pipeline register (skid buffer). It is the handshaking counterpart of the plain enable register: it generates the accept/enable decision itself from downstream backpressure instead of receiving an enable.
- Inserted on long datapaths between Deflate pipeline stages (e.g. hash/match stage to Huffman encoder) to break combinational ready paths.
- Full throughput: one transfer per cycle in steady state.

Parameters:
- N, 32, data width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  N  upstream data.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  slice can accept; registered, not combinationally dependent on out_ready.
- out_data  output  N  downstream data; driven directly from the main register.
- out_valid  output  1  out_data valid; registered.
- out_ready  input  1  downstream accepts.
- occupancy  output  2  number of held entries, 0..2; for debug and performance counters.

Behaviour:
- Transfer rules:
  - Input transfer when in_valid & in_ready at a rising clk edge.
  - Output transfer when out_valid & out_ready at a rising clk edge.
- Storage: main register (main_data, main_valid) and skid register (skid_data, skid_valid).
- Output mapping:
  - out_data = main_data.
  - out_valid = main_valid.
  - in_ready = ~skid_valid & init_done.
  - occupancy = main_valid + skid_valid.
- Reset (async assert, released synchronously by the surrounding reset logic):
  - main_data = 0, skid_data = 0, main_valid = 0, skid_valid = 0, init_done = 0.
  - Therefore out_valid = 0, out_data = 0, in_ready = 0, occupancy = 0.
- init_done goes to 1 on the first clk edge after reset deasserts. in_ready rises one cycle after reset release.
- State machine (encoded by main_valid/skid_valid):
  - EMPTY (0/0):
    - input transfer -> main_data <= in_data; go to BUSY.
    - otherwise stay.
  - BUSY (1/0):
    - input & output transfer -> main_data <= in_data; stay BUSY.
    - input transfer, no output transfer -> skid_data <= in_data; go to FULL. in_ready is 0 next cycle.
    - output transfer, no input transfer -> go to EMPTY.
    - neither -> hold.
  - FULL (1/1), in_ready = 0:
    - output transfer -> main_data <= skid_data; go to BUSY. in_ready is 1 next cycle.
    - otherwise hold.
  - Illegal (0/1): unreachable. The implementation recovers to EMPTY on the next edge.
- Latency: exactly one cycle from input transfer to out_valid when the slice is EMPTY.
- Ordering: strict FIFO; no data loss or duplication under any out_ready pattern.
- Data registers load only on the transitions listed above and hold otherwise. out_data must stay stable while out_valid = 1 and out_ready = 0.
- in_data is ignored when in_valid = 0 or in_ready = 0.
- Reset asserted mid-operation: both entries are discarded immediately (asynchronously). out_valid falls without waiting for a clock edge.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

Test Plan:
- Reset release, N=8:
  - Stimulus: hold in_valid = 1, in_data = 0x11 through reset and the first edge after release.
  - Required: in_ready = 0 at that edge and no capture. in_ready = 1 at the second edge; 0x11 is captured; out_valid = 1, out_data = 0x11 one cycle later; occupancy = 1.
- Streaming:
  - Stimulus: out_ready = 1 constantly; 16 consecutive words 0x00..0x0F.
  - Required: output is 0x00..0x0F on consecutive cycles, lagging input by 1 cycle; in_ready never drops; occupancy never exceeds 1.
- Backpressure fill:
  - Stimulus: send 0xA1, 0xA2, 0xA3 back to back with out_ready = 0.
  - Required: 0xA1 lands in main, 0xA2 in skid; in_ready = 0 after the second capture; 0xA3 is held upstream; occupancy = 2; out_data stays 0xA1.
- Drain from FULL:
  - Stimulus: continue from the previous case; set out_ready = 1 with in_valid held on 0xA3.
  - Required: output sequence 0xA1, 0xA2, 0xA3 with no gaps or repeats; in_ready returns to 1 one cycle after 0xA1 leaves.
- Random stress:
  - Stimulus: random in_valid and out_ready (50%) over 10k cycles, scoreboard compare.
  - Required: output equals input order exactly, and these assertions hold:
    - stable out_data under stall;
    - in_ready == ~(occupancy == 2) after init;
    - no combinational out_ready -> in_ready path.
- Mid-operation reset:
  - Stimulus: with occupancy = 2 (0x55, 0x66), pulse reset between clock edges.
  - Required: out_valid, in_ready, occupancy and out_data go to 0 immediately; after release, neither 0x55 nor 0x66 ever appears at the output.
